// File: rtl/writeback_arbiter_if.sv
// -----------------------------------------------------------------------------
// writeback_arbiter_if
// Bundles the register-file writeback traffic around writeback_arbiter.
//   pipe_wen/pipe_waddr/pipe_wdata : single-cycle pipeline writeback request
//   slow_valid/slow_waddr/slow_wdata: long-latency (load, mul/div) request
//   slow_ready                      : arbiter can take a slow request now
//   stall_pipe                      : pipeline must not issue a write now
//   rf_wen/rf_waddr/rf_wdata        : registered register-file write port
//   err_drop                        : sticky, a pipeline write was discarded
// Modports:
//   slave  : the arbiter side
//   master : the pipeline / slow-unit / register-file side
// -----------------------------------------------------------------------------
interface writeback_arbiter_if;
  logic        pipe_wen;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        slow_valid;
  logic [4:0]  slow_waddr;
  logic [31:0] slow_wdata;
  logic        slow_ready;
  logic        stall_pipe;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        err_drop;

  modport slave (
    input  pipe_wen, pipe_waddr, pipe_wdata,
    input  slow_valid, slow_waddr, slow_wdata,
    output slow_ready, stall_pipe,
    output rf_wen, rf_waddr, rf_wdata, err_drop
  );

  modport master (
    output pipe_wen, pipe_waddr, pipe_wdata,
    output slow_valid, slow_waddr, slow_wdata,
    input  slow_ready, stall_pipe,
    input  rf_wen, rf_waddr, rf_wdata, err_drop
  );
endinterface

// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
// Shares one register-file write port between the single-cycle pipeline and a
// long-latency source. Slow writes are buffered in a small in-order FIFO and
// normally fill idle pipeline slots; if the FIFO head waits STARVE_LIMIT
// cycles, stall_pipe pulses for one cycle and the head is forced through.
// Ports:
//   clk : sole clock, rising edge
//   rst : asynchronous, active-low reset
//   wb  : writeback_arbiter_if.slave (pipeline, slow source, rf port, err_drop)
// Parameters:
//   FIFO_DEPTH   : slow-write buffer entries (power of two, >= 2)
//   STARVE_LIMIT : cycles a buffered write may wait before stalling (1..15)
// -----------------------------------------------------------------------------
module writeback_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  writeback_arbiter_if.slave  wb
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // FIFO storage needs no reset: an entry is only read while count covers it.
  logic [4:0]       addr_mem [FIFO_DEPTH];
  logic [31:0]      data_mem [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [3:0]       starve_reg, starve_next;
  logic             rf_wen_reg;
  logic [4:0]       rf_waddr_reg;
  logic [31:0]      rf_wdata_reg;
  logic             err_drop_reg;

  logic             fifo_empty;
  logic             stall;
  logic             pipe_valid;
  logic             grant_pipe;
  logic             grant_fifo;
  logic             drop;
  logic             push;
  logic             pop;

  assign fifo_empty = (count_reg == '0);
  assign stall      = (starve_reg == 4'(STARVE_LIMIT));

  // Writes to x0 are architecturally void: they never win the port.
  assign pipe_valid = wb.pipe_wen && (wb.pipe_waddr != 5'd0);

  // The starvation counter is cleared whenever the FIFO is empty, so a stall
  // always has a head entry to force through.
  assign grant_fifo = !fifo_empty && (stall || !pipe_valid);
  assign grant_pipe = pipe_valid && !stall;
  assign drop       = pipe_valid && stall;

  // No pass-through: a full buffer refuses even if it pops this cycle.
  assign wb.slow_ready = (count_reg < CNT_W'(FIFO_DEPTH));
  assign push          = wb.slow_valid && wb.slow_ready && (wb.slow_waddr != 5'd0);
  assign pop           = grant_fifo;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    starve_next = starve_reg;
    if (pop || fifo_empty) begin
      starve_next = 4'd0;
    end else if (starve_reg != 4'(STARVE_LIMIT)) begin
      starve_next = starve_reg + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= wb.slow_waddr;
      data_mem[wr_ptr_reg] <= wb.slow_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      starve_reg   <= 4'd0;
      rf_wen_reg   <= 1'b0;
      rf_waddr_reg <= 5'd0;
      rf_wdata_reg <= 32'd0;
      err_drop_reg <= 1'b0;
    end else begin
      // Power-of-two depth: pointer overflow is the modulo wrap.
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg  <= count_next;
      starve_reg <= starve_next;

      rf_wen_reg <= grant_pipe || grant_fifo;
      if (grant_pipe) begin
        rf_waddr_reg <= wb.pipe_waddr;
        rf_wdata_reg <= wb.pipe_wdata;
      end else if (grant_fifo) begin
        rf_waddr_reg <= addr_mem[rd_ptr_reg];
        rf_wdata_reg <= data_mem[rd_ptr_reg];
      end

      if (drop) err_drop_reg <= 1'b1;
    end
  end

  assign wb.stall_pipe = stall;
  assign wb.rf_wen     = rf_wen_reg;
  assign wb.rf_waddr   = rf_waddr_reg;
  assign wb.rf_wdata   = rf_wdata_reg;
  assign wb.err_drop   = err_drop_reg;

endmodule

// File: tb/tb_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_writeback_arbiter
// Directed stimulus for writeback_arbiter (FIFO_DEPTH=2, STARVE_LIMIT=4).
// The stimulus process pushes expected register-file writes and expected
// status values into queues; an independent monitor samples on the falling
// edge, pops and compares, and prints the summary.
// -----------------------------------------------------------------------------
module tb_writeback_arbiter;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  writeback_arbiter_if bus();

  writeback_arbiter #(
    .FIFO_DEPTH   (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  logic [36:0] exp_q [$];
  string       chk_name_q [$];
  logic [31:0] chk_act_q [$];
  logic [31:0] chk_exp_q [$];
  int          checks   = 0;
  int          failures = 0;
  bit          stim_done = 1'b0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pipe_wen   = 1'b0;
    bus.pipe_waddr = 5'd0;
    bus.pipe_wdata = 32'd0;
    bus.slow_valid = 1'b0;
    bus.slow_waddr = 5'd0;
    bus.slow_wdata = 32'd0;
  endtask

  task automatic drive_pipe(input logic [4:0] a, input logic [31:0] d);
    bus.pipe_wen   = 1'b1;
    bus.pipe_waddr = a;
    bus.pipe_wdata = d;
  endtask

  task automatic drive_slow(input logic [4:0] a, input logic [31:0] d);
    bus.slow_valid = 1'b1;
    bus.slow_waddr = a;
    bus.slow_wdata = d;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    chk_name_q.push_back(n);
    chk_act_q.push_back(act);
    chk_exp_q.push_back(exp);
  endtask

  // Monitor / scoreboard
  initial begin
    logic [36:0] e;
    string       n;
    logic [31:0] a, x;
    forever begin
      @(negedge clk);
      if (bus.rf_wen === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rf_write unexpected: got addr=%0d data=%h, required no write",
                   bus.rf_waddr, bus.rf_wdata);
        end else begin
          e = exp_q.pop_front();
          if ({bus.rf_waddr, bus.rf_wdata} !== e) begin
            failures++;
            $display("FAIL rf_write: got addr=%0d data=%h, required addr=%0d data=%h",
                     bus.rf_waddr, bus.rf_wdata, e[36:32], e[31:0]);
          end else begin
            $display("rf_write addr=%0d data=%h ok", bus.rf_waddr, bus.rf_wdata);
          end
        end
      end
      while (chk_name_q.size() > 0) begin
        n = chk_name_q.pop_front();
        a = chk_act_q.pop_front();
        x = chk_exp_q.pop_front();
        checks++;
        if (a !== x) begin
          failures++;
          $display("FAIL %s: got %h, required %h", n, a, x);
        end else begin
          $display("check %s = %h ok", n, a);
        end
      end
      if (stim_done) begin
        checks++;
        if (exp_q.size() != 0) begin
          failures++;
          $display("FAIL rf_write_missing: got %0d outstanding, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    idle();
    rst = 1'b0;
    #12;
    chk("reset_rf_wen",     32'(bus.rf_wen),     32'd0);
    chk("reset_rf_waddr",   32'(bus.rf_waddr),   32'd0);
    chk("reset_rf_wdata",   bus.rf_wdata,        32'd0);
    chk("reset_err_drop",   32'(bus.err_drop),   32'd0);
    chk("reset_slow_ready", 32'(bus.slow_ready), 32'd1);
    chk("reset_stall",      32'(bus.stall_pipe), 32'd0);
    cyc();
    rst = 1'b1;
    cyc();
    chk("release_rf_wen", 32'(bus.rf_wen), 32'd0);
    cyc();

    // Pipeline write, 1-cycle latency
    drive_pipe(5'd5, 32'h1234);
    expect_wr(5'd5, 32'h1234);
    cyc();
    idle();
    chk("pipe_lat1_wen",  32'(bus.rf_wen),   32'd1);
    chk("pipe_lat1_addr", 32'(bus.rf_waddr), 32'd5);
    cyc();
    chk("pipe_after_wen", 32'(bus.rf_wen),   32'd0);
    chk("pipe_hold_addr", 32'(bus.rf_waddr), 32'd5);

    // Slow write on idle pipe, 2-cycle latency
    chk("slow_ready_idle", 32'(bus.slow_ready), 32'd1);
    drive_slow(5'd7, 32'hCAFE);
    expect_wr(5'd7, 32'hCAFE);
    cyc();
    idle();
    chk("slow_n1_wen", 32'(bus.rf_wen), 32'd0);
    cyc();
    chk("slow_n2_wen",  32'(bus.rf_wen),   32'd1);
    chk("slow_n2_addr", 32'(bus.rf_waddr), 32'd7);
    cyc();

    // Contention: queued slow write starves behind a busy pipeline
    drive_slow(5'd3, 32'h33);
    cyc();
    idle();
    chk("contend_err_before", 32'(bus.err_drop), 32'd0);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("contend_stall_%0d", k), 32'(bus.stall_pipe), (k == 4) ? 32'd1 : 32'd0);
      drive_pipe(5'd9, 32'h900 + 32'(k));
      if (k == 4) expect_wr(5'd3, 32'h33);
      else        expect_wr(5'd9, 32'h900 + 32'(k));
      cyc();
    end
    idle();
    chk("contend_err_drop", 32'(bus.err_drop),   32'd1);
    chk("contend_stall_end", 32'(bus.stall_pipe), 32'd0);
    cyc();
    cyc();

    // Full buffer: third slow request waits for a pop
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("full_slow_ready_%0d", k), 32'(bus.slow_ready),
          (k <= 1 || k == 6) ? 32'd1 : 32'd0);
      chk($sformatf("full_stall_%0d", k), 32'(bus.stall_pipe), (k == 5) ? 32'd1 : 32'd0);
      drive_pipe(5'd9, 32'hA00 + 32'(k));
      if (k == 0)      drive_slow(5'd11, 32'hB11);
      else if (k == 1) drive_slow(5'd12, 32'hB12);
      else             drive_slow(5'd13, 32'hB13);
      if (k == 5) expect_wr(5'd11, 32'hB11);
      else        expect_wr(5'd9, 32'hA00 + 32'(k));
      cyc();
    end
    idle();
    expect_wr(5'd12, 32'hB12);
    expect_wr(5'd13, 32'hB13);
    for (int k = 0; k < 4; k++) cyc();

    // Zero register on both sources
    drive_slow(5'd14, 32'h1414);
    cyc();
    chk("zero_slow_ready", 32'(bus.slow_ready), 32'd1);
    drive_pipe(5'd0, 32'hDEAD);
    drive_slow(5'd0, 32'hBEEF);
    expect_wr(5'd14, 32'h1414);
    cyc();
    idle();
    chk("zero_grant_wen",  32'(bus.rf_wen),   32'd1);
    chk("zero_grant_addr", 32'(bus.rf_waddr), 32'd14);
    cyc();
    chk("zero_idle_wen",  32'(bus.rf_wen),   32'd0);
    chk("zero_hold_addr", 32'(bus.rf_waddr), 32'd14);
    chk("zero_hold_data", bus.rf_wdata,      32'h1414);
    cyc();
    cyc();

    // Reset with two entries buffered and starvation counter at 3
    for (int k = 0; k < 4; k++) begin
      drive_pipe(5'd9, 32'hC00 + 32'(k));
      if (k == 0)      drive_slow(5'd20, 32'hD20);
      else if (k == 1) drive_slow(5'd21, 32'hD21);
      else begin
        bus.slow_valid = 1'b0;
      end
      if (k < 3) expect_wr(5'd9, 32'hC00 + 32'(k));
      cyc();
    end
    idle();
    chk("prereset_slow_ready", 32'(bus.slow_ready), 32'd0);
    chk("prereset_stall",      32'(bus.stall_pipe), 32'd0);
    rst = 1'b0;
    #1;
    chk("midreset_rf_wen",     32'(bus.rf_wen),     32'd0);
    chk("midreset_rf_waddr",   32'(bus.rf_waddr),   32'd0);
    chk("midreset_rf_wdata",   bus.rf_wdata,        32'd0);
    chk("midreset_err_drop",   32'(bus.err_drop),   32'd0);
    chk("midreset_slow_ready", 32'(bus.slow_ready), 32'd1);
    chk("midreset_stall",      32'(bus.stall_pipe), 32'd0);
    cyc();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("postreset_wen_%0d", k), 32'(bus.rf_wen), 32'd0);
    end

    // Recovery after reset
    drive_pipe(5'd2, 32'hE2);
    expect_wr(5'd2, 32'hE2);
    cyc();
    idle();
    cyc();
    cyc();
    stim_done = 1'b1;
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 2, slow-source write buffer entries (power of two, >=2).
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 4, cycles a buffered write may wait before forcing a pipeline stall (1..15).
REQ-003 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have ports pipe_wen/pipe_waddr/pipe_wdata  input  1/5/32  single-cycle pipeline writeback request.
REQ-006 The block SHALL have ports slow_valid/slow_waddr/slow_wdata  input  1/5/32  long-latency (load/mul-div) writeback request.
REQ-007 The block SHALL have port slow_ready  output  1  buffer can accept a slow request this cycle.
REQ-008 The block SHALL have port stall_pipe  output  1  pipeline must not issue a write this cycle.
REQ-009 The block SHALL have ports rf_wen/rf_waddr/rf_wdata  output  1/5/32  register-file write port.
REQ-010 The block SHALL have port err_drop  output  1  sticky flag: a pipeline write was discarded.

Function
REQ-011 slow_ready SHALL be combinational: high iff buffer count < FIFO_DEPTH; no same-cycle pass-through when full.
REQ-012 A slow request SHALL be accepted on a cycle with slow_valid && slow_ready; accepted requests with slow_waddr==0 SHALL be discarded, not enqueued.
REQ-013 Accepted entries SHALL enter the FIFO tail and become eligible for grant on the next cycle (no bypass); strict in-order drain.
REQ-014 Grant per cycle, priority: (a) stall_pipe high and FIFO non-empty -> FIFO head; (b) pipe_wen && pipe_waddr!=0 -> pipeline; (c) FIFO non-empty -> FIFO head; (d) none.
REQ-015 pipe_wen with pipe_waddr==0 SHALL produce no write and SHALL NOT block a FIFO grant that cycle.
REQ-016 A valid pipeline write (pipe_wen, pipe_waddr!=0) presented while stall_pipe is high SHALL be dropped and SHALL set err_drop, which holds until reset.
REQ-017 rf_wen/rf_waddr/rf_wdata SHALL be registered: they reflect the grant of the previous cycle; rf_wen=0 when no grant, rf_waddr/rf_wdata hold last values when idle.
REQ-018 Pipeline write latency SHALL be 1 cycle; slow write minimum latency SHALL be 2 cycles (accept -> grant -> rf_wen).
REQ-019 FIFO pointers SHALL wrap modulo FIFO_DEPTH; simultaneous enqueue and dequeue SHALL leave count unchanged.
REQ-020 Starvation counter SHALL increment each cycle the FIFO is non-empty and not popped, clear on any pop or when empty, saturate at STARVE_LIMIT.
REQ-021 stall_pipe SHALL be high iff starvation counter == STARVE_LIMIT (decoded from a register); the FIFO head pops that cycle, so stall_pipe is a one-cycle pulse per starvation event.
REQ-022 The block SHALL NOT reorder or merge writes to equal addresses; WAW ordering between sources is the issuing stage's responsibility.

Reset
REQ-023 On rst low, asynchronously: FIFO empty, pointers 0, starvation counter 0, rf_wen=0, rf_waddr=0, rf_wdata=0, err_drop=0; stall_pipe=0 and slow_ready=1 follow combinationally.
REQ-024 Reset mid-operation SHALL discard all buffered entries and any grant in flight; no rf_wen pulse on the first edge after release.

Verification
REQ-025 Pipe only: pipe_wen=1, addr=5, data=0x1234 for one cycle -> next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234; then rf_wen=0.
REQ-026 Slow on idle pipe: slow_valid=1, addr=7, data=0xCAFE accepted cycle N -> rf_wen=1, addr 7, data 0xCAFE at cycle N+2.
REQ-027 Contention: slow write addr 3 queued, pipe_wen=1 (addr 9) continuously -> rf writes addr 9 for 4 cycles, stall_pipe pulses 1 cycle, pipe write that cycle dropped, err_drop=1, addr 3 written next cycle.
REQ-028 Full buffer: 2 slow writes accepted while pipe busy -> slow_ready=0; third slow_valid held until a pop, accepted the cycle slow_ready returns 1; drain order 1,2,3.
REQ-029 Zero register: pipe_waddr=0 with FIFO non-empty -> FIFO head granted that cycle; slow write to addr 0 accepted with slow_ready=1 and never appears on rf_wen.
REQ-030 Reset with 2 entries buffered and starvation counter at 3 -> outputs 0 immediately, slow_ready=1, no rf_wen after release until new requests.
